dropout_mask_sequencer: RTL

//  Layer-level controller for training-time dropout. Streams one layer of LANES-wide activation beats.

---
 rtl/dropout_pkg.sv | 34 +++
 rtl/dropout_lfsr32.sv | 28 ++
 rtl/dropout_mask_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dropout_pkg.sv
// Shared definitions for the dropout mask sequencer.
// Contents:
//   state_t          - layer controller states (IDLE, RUN, DRAIN)
//   LFSR_TAPS        - Galois feedback mask for x^32+x^22+x^2+x+1
//   DEFAULT_SEED     - base seed used out of reset
//   LANE_SEED_STRIDE - golden-ratio stride that decorrelates the lane seeds
//   ZERO_SEED_SUB    - substitute for a lane seed that would be all-zero
//   lane_seed()      - per-lane seed derivation
//   lfsr_next()      - one right-shift Galois step
package dropout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] LFSR_TAPS        = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED     = 32'hACE1_2B3D;
  localparam logic [31:0] LANE_SEED_STRIDE = 32'h9E37_79B9;
  localparam logic [31:0] ZERO_SEED_SUB    = 32'h0000_0001;

  // An all-zero state would lock the LFSR, so it is never allowed as a seed.
  function automatic logic [31:0] lane_seed(input logic [31:0] base, input int unsigned lane);
    logic [31:0] s;
    s = base ^ (LANE_SEED_STRIDE * lane);
    return (s == 32'h0) ? ZERO_SEED_SUB : s;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/dropout_lfsr32.sv
// One 32-bit Galois LFSR lane for the dropout mask generator.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset; loads seed
//   load  - load seed into the state
//   seed  - value loaded on reset or load
//   step  - advance one Galois step
//   value - current LFSR state
module dropout_lfsr32
  import dropout_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] value
);

  always_ff @(posedge clk) begin
    if (reset || load) begin
      value <= seed;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/dropout_mask_sequencer.sv
// Layer-level training-time dropout controller. Streams one layer of
// LANES-wide beats, masks each element against per-lane LFSR randoms and a
// 32-bit threshold, zeroes dropped elements and counts drops.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   cfg_we, cfg_thresh, cfg_seed,
//   cfg_len                         - configuration load (IDLE only)
//   start, train_mode               - begin a layer (IDLE only), mask enable
//   in_valid, in_ready, in_data     - input beat stream
//   out_valid, out_ready, out_data,
//   out_mask                        - output beat stream, 1 = kept lane
//   busy                            - controller not idle
//   layer_done                      - one-cycle completion pulse
//   drop_count                      - saturating dropped-element count
module dropout_mask_sequencer
  import dropout_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter int          LANES = 4,
  parameter int          LEN_W = 16,
  parameter logic [31:0] SEED  = DEFAULT_SEED
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [31:0]            cfg_thresh,
  input  logic [31:0]            cfg_seed,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic                   start,
  input  logic                   train_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_mask,
  output logic                   busy,
  output logic                   layer_done,
  output logic [LEN_W+2:0]       drop_count
);

  localparam int CNT_W = $clog2(LANES + 1);

  state_t                 state;
  logic [31:0]            thresh;
  logic [LEN_W-1:0]       len;
  logic [LEN_W-1:0]       beat_cnt;
  logic                   train;

  logic                   vld_p1;
  logic [LANES*WIDTH-1:0] data_p1;
  logic [LANES-1:0]       mask_p1;
  logic                   done_p1;
  logic [LEN_W+2:0]       drops_p1;

  logic                   cfg_ok;
  logic                   accept;
  logic [31:0]            seed_src;
  logic [LEN_W-1:0]       eff_len;
  logic [31:0]            lfsr_val [LANES];
  logic [LANES-1:0]       lane_mask;
  logic [LANES*WIDTH-1:0] masked;
  logic [CNT_W-1:0]       drop_n;

  function automatic logic [LEN_W+2:0] sat_add(input logic [LEN_W+2:0] acc,
                                               input logic [CNT_W-1:0] n);
    logic [LEN_W+3:0] sum;
    sum = {1'b0, acc} + (LEN_W+4)'(n);
    return sum[LEN_W+3] ? '1 : sum[LEN_W+2:0];
  endfunction

  assign cfg_ok   = cfg_we && (state == IDLE);
  assign in_ready = (state == RUN) && (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;
  // A config write in the start cycle takes effect for that layer.
  assign eff_len  = cfg_ok ? cfg_len : len;
  // Reset reloads the lanes from the default seed, not from the live input.
  assign seed_src = reset ? SEED : cfg_seed;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dropout_lfsr32 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (cfg_ok),
      .seed  (lane_seed(seed_src, i)),
      .step  (accept && train),
      .value (lfsr_val[i])
    );
  end

  always_comb begin
    lane_mask = '1;
    masked    = '0;
    drop_n    = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_mask[i] = !(train && (lfsr_val[i] < thresh));
      masked[i*WIDTH +: WIDTH] = lane_mask[i] ? in_data[i*WIDTH +: WIDTH] : '0;
      drop_n = drop_n + CNT_W'(!lane_mask[i]);
    end
  end

  // ---- stage p1: registered output beat, control FSM, statistics ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      thresh   <= '0;
      len      <= '0;
      beat_cnt <= '0;
      train    <= 1'b0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      mask_p1  <= '0;
      done_p1  <= 1'b0;
      drops_p1 <= '0;
    end else begin
      done_p1 <= 1'b0;
      if (vld_p1 && out_ready) begin
        vld_p1 <= 1'b0;
      end
      if (accept) begin
        vld_p1   <= 1'b1;
        data_p1  <= masked;
        mask_p1  <= lane_mask;
        drops_p1 <= sat_add(drops_p1, drop_n);
        beat_cnt <= beat_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (cfg_ok) begin
            thresh <= cfg_thresh;
            len    <= cfg_len;
          end
          if (start) begin
            if (eff_len != '0) begin
              state    <= RUN;
              beat_cnt <= '0;
              drops_p1 <= '0;
              train    <= train_mode;
            end else begin
              done_p1 <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept && (beat_cnt == len - 1'b1)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (vld_p1 && out_ready) begin
            state   <= IDLE;
            done_p1 <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = data_p1;
  assign out_mask   = mask_p1;
  assign busy       = (state != IDLE);
  assign layer_done = done_p1;
  assign drop_count = drops_p1;

endmodule
